// File: rtl/ext_int_acceptor_pkg.sv
// Shared constants for the external-interrupt acceptor: CSR addresses, bit positions, FSM encoding.
package ext_int_acceptor_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MEI_BIT          = 11;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned CAUSE_MEI_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_TAKE    = 2'd2,
    ST_HANDLER = 2'd3
  } acc_state_e;

endpackage

// File: rtl/ext_int_acceptor_csr_regs.sv
// Machine-mode CSR storage owned by the interrupt acceptor, plus the combinational read mux.
module ext_int_acceptor_csr_regs
  import ext_int_acceptor_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  MTVEC_RST = '0,
  parameter int unsigned      CAUSE_MEI = CAUSE_MEI_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [11:0]      csr_addr,
  input  logic             csr_we,
  input  logic [XLEN-1:0]  csr_wdata,
  input  logic             take,
  input  logic [XLEN-1:0]  take_pc,
  input  logic             mret,
  input  logic             ext_int_trigger,
  output logic             mie_bit,
  output logic             meie,
  output logic [XLEN-1:0]  mtvec,
  output logic [XLEN-1:0]  mepc,
  output logic [XLEN-1:0]  csr_rdata
);

  localparam logic [XLEN-1:0] MCAUSE_MEI = {1'b1, (XLEN-1)'(CAUSE_MEI)};

  logic            mpie;
  logic [XLEN-1:0] mcause;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

  always_comb begin
    wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
    wr_mie     = csr_we && (csr_addr == CSR_MIE);
    wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
    wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
    wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
  end

  // Trap entry beats mret, which beats a software write, for the shared mstatus bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie_bit <= 1'b0;
      mpie    <= 1'b0;
      meie    <= 1'b0;
      mtvec   <= MTVEC_RST;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      if (take) begin
        mie_bit <= 1'b0;
        mpie    <= mie_bit;
      end else if (mret) begin
        mie_bit <= mpie;
        mpie    <= 1'b1;
      end else if (wr_mstatus) begin
        mie_bit <= csr_wdata[MSTATUS_MIE_BIT];
        mpie    <= csr_wdata[MSTATUS_MPIE_BIT];
      end

      if (wr_mie)
        meie <= csr_wdata[MEI_BIT];

      if (wr_mtvec)
        mtvec <= {csr_wdata[XLEN-1:2], 2'b00};

      if (take)
        mepc <= take_pc;
      else if (wr_mepc)
        mepc <= {csr_wdata[XLEN-1:2], 2'b00};

      if (take)
        mcause <= MCAUSE_MEI;
      else if (wr_mcause)
        mcause <= csr_wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mie_bit;
        csr_rdata[MSTATUS_MPIE_BIT] = mpie;
      end
      CSR_MIE:    csr_rdata[MEI_BIT] = meie;
      CSR_MTVEC:  csr_rdata = mtvec;
      CSR_MEPC:   csr_rdata = mepc;
      CSR_MCAUSE: csr_rdata = mcause;
      CSR_MIP:    csr_rdata[MEI_BIT] = ext_int_trigger;
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/ext_int_acceptor.sv
// Core-side external-interrupt acceptor: gates EIC requests, traps at instruction boundaries, handles mret.
module ext_int_acceptor
  import ext_int_acceptor_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  MTVEC_RST = '0,
  parameter int unsigned      CAUSE_MEI = CAUSE_MEI_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ext_int_trigger,
  output logic             ext_int_handled,
  input  logic             instr_boundary,
  input  logic [XLEN-1:0]  pc_next,
  input  logic             mret,
  output logic             trap_req,
  output logic [XLEN-1:0]  trap_pc,
  output logic             ret_req,
  input  logic [11:0]      csr_addr,
  input  logic             csr_we,
  input  logic [XLEN-1:0]  csr_wdata,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             in_handler
);

  acc_state_e      state, state_nxt;
  logic [XLEN-1:0] pc_lat;
  logic            mie_bit, meie, enabled, take;
  logic [XLEN-1:0] mtvec, mepc;

  assign enabled = mie_bit & meie;
  assign take    = (state == ST_TAKE);

  ext_int_acceptor_csr_regs #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST),
    .CAUSE_MEI (CAUSE_MEI)
  ) u_csr (
    .clk             (clk),
    .rstn            (rstn),
    .csr_addr        (csr_addr),
    .csr_we          (csr_we),
    .csr_wdata       (csr_wdata),
    .take            (take),
    .take_pc         (pc_lat),
    .mret            (mret),
    .ext_int_trigger (ext_int_trigger),
    .mie_bit         (mie_bit),
    .meie            (meie),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .csr_rdata       (csr_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      pc_lat <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_PEND && state_nxt == ST_TAKE)
        pc_lat <= pc_next;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (ext_int_trigger && enabled)
          state_nxt = ST_PEND;
      ST_PEND:
        if (!ext_int_trigger || !enabled)
          state_nxt = ST_IDLE;
        else if (instr_boundary)
          state_nxt = ST_TAKE;
      ST_TAKE:
        state_nxt = ST_HANDLER;
      ST_HANDLER:
        if (mret)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // mret is honoured in every state so software sees the mstatus restore even without a trap.
  always_comb begin
    trap_req        = take;
    ext_int_handled = take;
    ret_req         = mret;
    in_handler      = (state == ST_TAKE) || (state == ST_HANDLER);
    trap_pc         = take ? mtvec : mepc;
  end

endmodule

// File: tb/tb_ext_int_acceptor.sv
// Directed self-checking bench for ext_int_acceptor.
module tb_ext_int_acceptor;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ext_int_trigger = 1'b0;
  logic        ext_int_handled;
  logic        instr_boundary = 1'b0;
  logic [31:0] pc_next = '0;
  logic        mret = 1'b0;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        ret_req;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        in_handler;

  int checks = 0;
  int failures = 0;
  int handled_cnt = 0;
  int trap_cnt = 0;

  ext_int_acceptor #(
    .XLEN      (32),
    .MTVEC_RST (MTVEC_RST),
    .CAUSE_MEI (11)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ext_int_trigger (ext_int_trigger),
    .ext_int_handled (ext_int_handled),
    .instr_boundary  (instr_boundary),
    .pc_next         (pc_next),
    .mret            (mret),
    .trap_req        (trap_req),
    .trap_pc         (trap_pc),
    .ret_req         (ret_req),
    .csr_addr        (csr_addr),
    .csr_we          (csr_we),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .in_handler      (in_handler)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ext_int_handled) handled_cnt++;
    if (trap_req) trap_cnt++;
  end

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1 d = csr_rdata;
  endtask

  task automatic wait_trap(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trap_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_mret(output logic rr, output logic [31:0] pc);
    mret = 1'b1;
    #1;
    rr = ret_req; pc = trap_pc;
    @(negedge clk);
    mret = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #1;
    checks++;
    if ({trap_req, ext_int_handled, ret_req, in_handler} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {trap_req, ext_int_handled, ret_req, in_handler});
    end
    csr_read(12'h300, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_mstatus got=%h exp=00000000", v); end
    csr_read(12'h305, v); checks++;
    if (v !== MTVEC_RST) begin failures++; $display("FAIL reset_mtvec got=%h exp=%h", v, MTVEC_RST); end
    csr_read(12'h341, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h exp=00000000", v); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_csr;
    logic [31:0] v;
    csr_write(12'h342, 32'hDEAD_BEEF);
    csr_read(12'h342, v); checks++;
    if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mcause_rw got=%h exp=deadbeef", v); end
    csr_write(12'h341, 32'h0000_0123);
    csr_read(12'h341, v); checks++;
    if (v !== 32'h0000_0120) begin failures++; $display("FAIL mepc_align got=%h exp=00000120", v); end
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_read(12'h300, v); checks++;
    if (v !== 32'h0000_0088) begin failures++; $display("FAIL mstatus_mask got=%h exp=00000088", v); end
    csr_read(12'h123, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=00000000", v); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    logic rr;
    logic [31:0] rpc;
    int h0;
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h800);
    csr_write(12'h305, 32'h0000_1003);
    h0 = handled_cnt;
    instr_boundary = 1'b1; pc_next = 32'h100; ext_int_trigger = 1'b1;
    @(negedge clk); checks++;
    if (trap_req !== 1'b0) begin failures++; $display("FAIL basic_early_trap got=%b exp=0", trap_req); end
    @(negedge clk); checks++;
    if ({trap_req, ext_int_handled, in_handler} !== 3'b111 || trap_pc !== 32'h1000) begin
      failures++; $display("FAIL basic_take got=%b pc=%h exp=111 pc=00001000", {trap_req, ext_int_handled, in_handler}, trap_pc);
    end
    ext_int_trigger = 1'b0; pc_next = 32'h999;
    @(negedge clk); checks++;
    if ({trap_req, ext_int_handled, in_handler} !== 3'b001) begin
      failures++; $display("FAIL basic_handler got=%b exp=001", {trap_req, ext_int_handled, in_handler});
    end
    csr_read(12'h341, v); checks++;
    if (v !== 32'h100) begin failures++; $display("FAIL basic_mepc got=%h exp=00000100", v); end
    csr_read(12'h342, v); checks++;
    if (v !== 32'h8000_000B) begin failures++; $display("FAIL basic_mcause got=%h exp=8000000b", v); end
    csr_read(12'h300, v); checks++;
    if (v !== 32'h80) begin failures++; $display("FAIL basic_mstatus got=%h exp=00000080", v); end
    pulse_mret(rr, rpc); checks++;
    if (rr !== 1'b1 || rpc !== 32'h100) begin failures++; $display("FAIL basic_ret got=%b pc=%h exp=1 pc=00000100", rr, rpc); end
    csr_read(12'h300, v); checks++;
    if (v !== 32'h88 || in_handler !== 1'b0) begin
      failures++; $display("FAIL basic_restore got=%h ih=%b exp=00000088 ih=0", v, in_handler);
    end
    checks++;
    if (handled_cnt - h0 !== 1) begin failures++; $display("FAIL basic_handled_count got=%0d exp=1", handled_cnt - h0); end
  endtask

  task automatic test_two_flags;
    bit ok;
    logic rr;
    logic [31:0] rpc;
    int h0, t0;
    h0 = handled_cnt;
    pc_next = 32'h200; instr_boundary = 1'b1; ext_int_trigger = 1'b1;
    wait_trap(10, ok); checks++;
    if (!ok) begin failures++; $display("FAIL two_first_trap got=timeout exp=trap_req"); end
    @(negedge clk);
    t0 = trap_cnt;
    csr_write(12'h300, 32'h88);
    repeat (4) @(negedge clk);
    checks++;
    if (trap_cnt !== t0 || in_handler !== 1'b1) begin
      failures++; $display("FAIL two_no_nesting got=traps+%0d ih=%b exp=traps+0 ih=1", trap_cnt - t0, in_handler);
    end
    pulse_mret(rr, rpc); checks++;
    if (rr !== 1'b1 || rpc !== 32'h200) begin failures++; $display("FAIL two_ret got=%b pc=%h exp=1 pc=00000200", rr, rpc); end
    wait_trap(10, ok); checks++;
    if (!ok) begin failures++; $display("FAIL two_second_trap got=timeout exp=trap_req"); end
    ext_int_trigger = 1'b0;
    @(negedge clk);
    pulse_mret(rr, rpc);
    @(negedge clk); checks++;
    if (handled_cnt - h0 !== 2) begin failures++; $display("FAIL two_handled_count got=%0d exp=2", handled_cnt - h0); end
  endtask

  task automatic test_cancel;
    int h0, t0;
    h0 = handled_cnt; t0 = trap_cnt;
    instr_boundary = 1'b0; ext_int_trigger = 1'b1;
    @(negedge clk);
    ext_int_trigger = 1'b0;
    @(negedge clk);
    instr_boundary = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (handled_cnt !== h0 || trap_cnt !== t0 || in_handler !== 1'b0) begin
      failures++; $display("FAIL cancel got=h+%0d t+%0d ih=%b exp=h+0 t+0 ih=0", handled_cnt - h0, trap_cnt - t0, in_handler);
    end
  endtask

  task automatic test_disabled;
    logic [31:0] v;
    logic rr;
    logic [31:0] rpc;
    bit ok;
    int h0;
    csr_write(12'h304, 32'h0);
    h0 = handled_cnt;
    instr_boundary = 1'b1; ext_int_trigger = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (handled_cnt !== h0) begin failures++; $display("FAIL disabled_no_pulse got=%0d exp=0", handled_cnt - h0); end
    csr_read(12'h344, v); checks++;
    if (v !== 32'h800) begin failures++; $display("FAIL disabled_mip got=%h exp=00000800", v); end
    csr_write(12'h304, 32'h800);
    wait_trap(10, ok); checks++;
    if (!ok) begin failures++; $display("FAIL disabled_enable_trap got=timeout exp=trap_req"); end
    ext_int_trigger = 1'b0;
    @(negedge clk);
    pulse_mret(rr, rpc);
  endtask

  task automatic test_collision;
    logic [31:0] v;
    logic rr;
    logic [31:0] rpc;
    pc_next = 32'h340; instr_boundary = 1'b1; ext_int_trigger = 1'b1;
    @(negedge clk);
    @(negedge clk); checks++;
    if (trap_req !== 1'b1) begin failures++; $display("FAIL collision_take got=%b exp=1", trap_req); end
    csr_write(12'h300, 32'h8);
    ext_int_trigger = 1'b0;
    csr_read(12'h300, v); checks++;
    if (v !== 32'h80) begin failures++; $display("FAIL collision_mstatus got=%h exp=00000080", v); end
    csr_read(12'h341, v); checks++;
    if (v !== 32'h340) begin failures++; $display("FAIL collision_mepc got=%h exp=00000340", v); end
    pulse_mret(rr, rpc);
  endtask

  task automatic test_reset_mid_handler;
    logic [31:0] v;
    logic rr;
    logic [31:0] rpc;
    bit ok;
    ext_int_trigger = 1'b1; instr_boundary = 1'b1; pc_next = 32'h444;
    wait_trap(10, ok);
    @(negedge clk);
    ext_int_trigger = 1'b0;
    rstn = 1'b0;
    #1; checks++;
    if ({trap_req, ext_int_handled, ret_req, in_handler} !== 4'b0000) begin
      failures++; $display("FAIL midreset_outputs got=%b exp=0000", {trap_req, ext_int_handled, ret_req, in_handler});
    end
    csr_read(12'h305, v); checks++;
    if (v !== MTVEC_RST) begin failures++; $display("FAIL midreset_mtvec got=%h exp=%h", v, MTVEC_RST); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pulse_mret(rr, rpc); checks++;
    if (rr !== 1'b1 || in_handler !== 1'b0) begin
      failures++; $display("FAIL mret_outside got=%b ih=%b exp=1 ih=0", rr, in_handler);
    end
    csr_read(12'h300, v); checks++;
    if (v !== 32'h80) begin failures++; $display("FAIL mret_outside_mstatus got=%h exp=00000080", v); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_csr;
    test_basic;
    test_two_flags;
    test_cancel;
    test_disabled;
    test_collision;
    test_reset_mid_handler;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
